commit_unit: RTL and testbench
==============================

# commit_unit

Writeback/commit stage on the consumer side of the ALU result interface. It collects results from up to `NUM_UNITS` execution units (`res`/`rd`/`valid`/`error`/`req`) and commits one per cycle under round-robin arbitration. A commit either writes the register file, redirects the PC on a taken branch, or raises a trap. It returns a `clear` pulse to the granted unit so that unit can release its output latch.

## Interface
- `NUM_UNITS`, 4: number of execution units serviced (2..8).
- `XLEN`, `core_config_pkg::XLEN`: data width.
- `REG_ADDR_W`, `core_config_pkg::REG_ADDR_W`: register address width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `unit_res` in `NUM_UNITS*XLEN`: per-unit result or branch target; unit i occupies bits `[i*XLEN +: XLEN]`.
- `unit_rd` in `NUM_UNITS*REG_ADDR_W`: per-unit destination register.
- `unit_valid` in `NUM_UNITS`: per-unit result-present flag.
- `unit_error` in `NUM_UNITS`: per-unit overflow/error flag.
- `unit_req` in `NUM_UNITS`: per-unit redirect request (taken branch).
- `unit_clear` out `NUM_UNITS`: per-unit consume pulse (combinational, same cycle as grant).
- `rf_we` out 1: register-file write enable.
- `rf_waddr` out `REG_ADDR_W`: write address.
- `rf_wdata` out `XLEN`: write data.
- `pc_redirect` out 1: one-cycle redirect strobe.
- `pc_target` out `XLEN`: redirect target.
- `flush` out 1: high during the FLUSH state.
- `trap_valid` out 1: trap pending.
- `trap_unit` out `$clog2(NUM_UNITS)`: index of the faulting unit.
- `trap_ack` in 1: trap handler acknowledge.
- `retired` out 64: commit counter (see Configuration).

## Operation
- States: RUN, FLUSH, TRAP. Reset state is RUN.
- RUN:
  - Candidates are the units with `unit_valid=1`.
  - Grant goes to the first candidate at or after `rr_ptr`, wrapping modulo `NUM_UNITS`.
  - `unit_clear[grant]=1` in the same cycle; all other `unit_clear` bits are 0.
  - `rr_ptr` then advances to `(grant+1) mod NUM_UNITS`.
  - If there are no candidates: no grant and `rr_ptr` holds.
- Priority on the granted unit: `error` > `req` > write.
  - `error=1`: no write, no redirect. Register `trap_valid=1` and `trap_unit=grant`, then go to TRAP.
  - `req=1`: no write. Register `pc_redirect=1` and `pc_target=res`, then go to FLUSH.
  - Otherwise: register `rf_we=(rd!=0)`, `rf_waddr=rd`, `rf_wdata=res`. A commit to x0 is consumed and counted but not written.
- FLUSH (exactly one cycle):
  - `flush=1`.
  - `unit_clear = unit_valid` (all pending results discarded, not counted).
  - No writes. Return to RUN.
- TRAP:
  - `unit_clear=0` and no writes; units keep their results.
  - `trap_valid` and `trap_unit` hold.
  - On `trap_ack=1`: clear `trap_valid` and go to FLUSH (discard in-flight work).
- A `trap_ack` received outside TRAP is ignored.

## Timing
- Commit latency: `unit_valid` seen at edge N produces `rf_we`/`pc_redirect`/`trap_valid` registered at edge N+1.
- Throughput: one commit per cycle in RUN.
- `rf_we` and `pc_redirect` are single-cycle pulses. They default to 0 on every cycle without a matching commit.
- Registered outputs: `rf_waddr`, `rf_wdata`, and `pc_target` hold their last value when not strobed.
- Reset values (asynchronous):
  - All registered outputs are 0: `rf_we`, `rf_waddr`, `rf_wdata`, `pc_redirect`, `pc_target`, `trap_valid`, `trap_unit`, `retired`.
  - `flush=0`, `unit_clear=0`, `rr_ptr=0`, state RUN.
- Reset asserted mid-operation aborts any pending redirect or trap immediately.
- Simultaneous valids from all units: served strictly round-robin, so no unit waits more than `NUM_UNITS-1` grants.
- `rr_ptr` wraps from `NUM_UNITS-1` to 0.

## Configuration
- `COMMIT_PERF_CNT_EN` defined:
  - `retired` is a 64-bit counter, incremented by 1 on each non-trapping RUN commit (writes, x0 writes, redirects).
  - Wraps modulo 2^64.
- Not defined:
  - `retired` is tied to 0 and no counter flops are synthesized.

## Test plan
- Single write: unit 1 presents `res=0x0000_0005`, `rd=3`, `valid=1` → `unit_clear=4'b0010` in the same cycle; next cycle `rf_we=1`, `rf_waddr=3`, `rf_wdata=5`.
- Fairness: all 4 units valid continuously from reset → grants in order 0,1,2,3,0 on consecutive cycles; `retired` reads 5 after 5 commits (with `COMMIT_PERF_CNT_EN`).
- Redirect: unit 2 presents `req=1`, `res=0x0000_0100` while units 0 and 3 are valid → `pc_redirect=1` and `pc_target=0x100`. Next cycle `flush=1`, `unit_clear=4'b1001`, no `rf_we`.
- Trap: unit 3 presents `error=1` and `req=1` → `trap_valid=1`, `trap_unit=3`, no redirect. `unit_clear` stays 0 until `trap_ack`; then one FLUSH cycle, then RUN.
- x0 and reset: unit 0 presents `rd=0` → `rf_we` stays 0, `unit_clear[0]=1`, `retired` increments. Asserting `rst_n=0` during TRAP → all outputs 0 and state RUN.

Source files
------------

// File: rtl/commit_unit.sv
// Writeback/commit stage: round-robin commit of execution-unit results to the
// register file, PC redirect on taken branches, or trap. Optional retire
// counter enabled by defining COMMIT_PERF_CNT_EN.
//
// state    | meaning
// ST_RUN   | arbitrate and commit one result per cycle
// ST_FLUSH | one cycle discarding every pending unit result
// ST_TRAP  | hold trap until trap_ack, units keep their results

package core_config_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
endpackage

module commit_unit #(
  parameter int NUM_UNITS  = 4,
  parameter int XLEN       = core_config_pkg::XLEN,
  parameter int REG_ADDR_W = core_config_pkg::REG_ADDR_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_UNITS*XLEN-1:0]       unit_res,
  input  logic [NUM_UNITS*REG_ADDR_W-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0]            unit_valid,
  input  logic [NUM_UNITS-1:0]            unit_error,
  input  logic [NUM_UNITS-1:0]            unit_req,
  output logic [NUM_UNITS-1:0]            unit_clear,
  output logic                           rf_we,
  output logic [REG_ADDR_W-1:0]           rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic                           pc_redirect,
  output logic [XLEN-1:0]                 pc_target,
  output logic                           flush,
  output logic                           trap_valid,
  output logic [$clog2(NUM_UNITS)-1:0]    trap_unit,
  input  logic                           trap_ack,
  output logic [63:0]                    retired
);

  localparam int IDX_W = $clog2(NUM_UNITS);

  typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_TRAP} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
  logic                  pc_redirect_q, pc_redirect_d;
  logic [XLEN-1:0]       pc_target_q, pc_target_d;
  logic                  trap_valid_q, trap_valid_d;
  logic [IDX_W-1:0]      trap_unit_q, trap_unit_d;
  logic                  commit_inc;

  logic                  gnt_found;
  logic [IDX_W-1:0]      gnt_idx;
  logic [XLEN-1:0]       gnt_res;
  logic [REG_ADDR_W-1:0] gnt_rd;
  logic                  gnt_err;
  logic                  gnt_req;

  always_comb begin
    int cand;
    cand      = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = (int'(rr_ptr_q) + k) % NUM_UNITS;
      if (!gnt_found && unit_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

  assign gnt_res = unit_res[int'(gnt_idx)*XLEN +: XLEN];
  assign gnt_rd  = unit_rd[int'(gnt_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign gnt_err = unit_error[gnt_idx];
  assign gnt_req = unit_req[gnt_idx];

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    unit_clear    = '0;
    flush         = 1'b0;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    pc_redirect_d = 1'b0;
    pc_target_d   = pc_target_q;
    trap_valid_d  = trap_valid_q;
    trap_unit_d   = trap_unit_q;
    commit_inc    = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Gated by rst_n so no consume pulse escapes while reset is held.
        if (gnt_found && rst_n) begin
          unit_clear[gnt_idx] = 1'b1;
          rr_ptr_d = (int'(gnt_idx) == NUM_UNITS - 1) ? '0 : gnt_idx + IDX_W'(1);
          if (gnt_err) begin
            trap_valid_d = 1'b1;
            trap_unit_d  = gnt_idx;
            state_d      = ST_TRAP;
          end else if (gnt_req) begin
            pc_redirect_d = 1'b1;
            pc_target_d   = gnt_res;
            commit_inc    = 1'b1;
            state_d       = ST_FLUSH;
          end else begin
            rf_we_d    = (gnt_rd != '0);
            rf_waddr_d = gnt_rd;
            rf_wdata_d = gnt_res;
            commit_inc = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        flush      = 1'b1;
        unit_clear = unit_valid;
        state_d    = ST_RUN;
      end
      ST_TRAP: begin
        if (trap_ack) begin
          trap_valid_d = 1'b0;
          state_d      = ST_FLUSH;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      rr_ptr_q      <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      pc_redirect_q <= 1'b0;
      pc_target_q   <= '0;
      trap_valid_q  <= 1'b0;
      trap_unit_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      pc_redirect_q <= pc_redirect_d;
      pc_target_q   <= pc_target_d;
      trap_valid_q  <= trap_valid_d;
      trap_unit_q   <= trap_unit_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pc_redirect = pc_redirect_q;
  assign pc_target   = pc_target_q;
  assign trap_valid  = trap_valid_q;
  assign trap_unit   = trap_unit_q;

`ifdef COMMIT_PERF_CNT_EN
  logic [63:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + 64'(commit_inc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  logic unused_commit_inc;
  assign unused_commit_inc = commit_inc;
  assign retired = '0;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: scoreboard of expected grants/writes,
// one task per scenario. Retire counts are expected only with COMMIT_PERF_CNT_EN.
module tb_commit_unit;
  localparam int NU = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NU*XL-1:0] unit_res;
  logic [NU*RW-1:0] unit_rd;
  logic [NU-1:0]   unit_valid, unit_error, unit_req, unit_clear;
  logic            rf_we, pc_redirect, flush, trap_valid, trap_ack;
  logic [RW-1:0]   rf_waddr;
  logic [XL-1:0]   rf_wdata, pc_target;
  logic [1:0]      trap_unit;
  logic [63:0]     retired;

  typedef struct {
    logic [NU-1:0] clr;
    logic [RW-1:0] addr;
    logic [XL-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ret_model = 0;

  commit_unit #(.NUM_UNITS(NU), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .unit_res(unit_res), .unit_rd(unit_rd),
    .unit_valid(unit_valid), .unit_error(unit_error), .unit_req(unit_req),
    .unit_clear(unit_clear), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flush(flush), .trap_valid(trap_valid), .trap_unit(trap_unit),
    .trap_ack(trap_ack), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_ret();
`ifdef COMMIT_PERF_CNT_EN
    return 64'(ret_model);
`else
    return 64'd0;
`endif
  endfunction

  task automatic set_unit(input int i, input logic [XL-1:0] res, input logic [RW-1:0] rd,
                          input logic v, input logic e, input logic r);
    unit_res[i*XL +: XL] = res;
    unit_rd[i*RW +: RW]  = rd;
    unit_valid[i] = v;
    unit_error[i] = e;
    unit_req[i]   = r;
  endtask

  task automatic clear_all();
    unit_res = '0; unit_rd = '0; unit_valid = '0; unit_error = '0; unit_req = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; trap_ack = 1'b0; clear_all();
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0h want 0", rf_we); end
    n_checks++; if (rf_waddr !== '0) begin n_fail++; $display("FAIL reset_rf_waddr got %0h want 0", rf_waddr); end
    n_checks++; if (rf_wdata !== '0) begin n_fail++; $display("FAIL reset_rf_wdata got %0h want 0", rf_wdata); end
    n_checks++; if (pc_redirect !== 1'b0) begin n_fail++; $display("FAIL reset_pc_redirect got %0h want 0", pc_redirect); end
    n_checks++; if (pc_target !== '0) begin n_fail++; $display("FAIL reset_pc_target got %0h want 0", pc_target); end
    n_checks++; if (trap_valid !== 1'b0 || trap_unit !== 2'd0) begin n_fail++; $display("FAIL reset_trap got %0h/%0h want 0/0", trap_valid, trap_unit); end
    n_checks++; if (retired !== 64'd0) begin n_fail++; $display("FAIL reset_retired got %0h want 0", retired); end
    n_checks++; if (flush !== 1'b0 || unit_clear !== 4'b0000) begin n_fail++; $display("FAIL reset_flush_clear got %0h/%b want 0/0000", flush, unit_clear); end
    next_cycle();
    rst_n = 1'b1;
    ret_model = 0;
  endtask

  task automatic test_single_write();
    exp_t e;
    set_unit(1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0);
    sb.push_back('{clr: 4'b0010, addr: 5'd3, data: 32'd5});
    @(negedge clk);
    n_checks++; if (unit_clear !== sb[0].clr) begin n_fail++; $display("FAIL single_clear got %b want %b", unit_clear, sb[0].clr); end
    next_cycle();
    clear_all();
    @(negedge clk);
    e = sb.pop_front();
    ret_model++;
    n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_rf_we got %0h want 1", rf_we); end
    n_checks++; if (rf_waddr !== e.addr || rf_wdata !== e.data) begin n_fail++; $display("FAIL single_write got %0h:%0h want %0h:%0h", rf_waddr, rf_wdata, e.addr, e.data); end
    n_checks++; if (retired !== exp_ret()) begin n_fail++; $display("FAIL single_retired got %0d want %0d", retired, exp_ret()); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0 || rf_wdata !== 32'd5) begin n_fail++; $display("FAIL single_pulse_hold got %0h/%0h want 0/5", rf_we, rf_wdata); end
  endtask

  task automatic test_fairness();
    exp_t e, prev;
    bit have_prev;
    rst_n = 1'b0; clear_all();
    next_cycle();
    rst_n = 1'b1;
    ret_model = 0;
    for (int i = 0; i < NU; i++) set_unit(i, 32'h10 + XL'(i), RW'(i + 1), 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      int g;
      g = c % NU;
      sb.push_back('{clr: NU'(1) << g, addr: RW'(g + 1), data: 32'h10 + XL'(g)});
    end
    have_prev = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (have_prev) begin
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== prev.addr || rf_wdata !== prev.data) begin n_fail++; $display("FAIL fair_write%0d got %0h:%0h:%0h want 1:%0h:%0h", c, rf_we, rf_waddr, rf_wdata, prev.addr, prev.data); end
      end
      e = sb.pop_front();
      n_checks++; if (unit_clear !== e.clr) begin n_fail++; $display("FAIL fair_grant%0d got %b want %b", c, unit_clear, e.clr); end
      prev = e; have_prev = 1'b1;
      ret_model++;
      next_cycle();
    end
    clear_all();
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== prev.addr || rf_wdata !== prev.data) begin n_fail++; $display("FAIL fair_write_last got %0h:%0h:%0h want 1:%0h:%0h", rf_we, rf_waddr, rf_wdata, prev.addr, prev.data); end
    n_checks++; if (retired !== exp_ret()) begin n_fail++; $display("FAIL fair_retired got %0d want %0d", retired, exp_ret()); end
    next_cycle();
  endtask

  task automatic test_redirect();
    set_unit(0, 32'h70, 5'd7, 1'b1, 1'b0, 1'b0);
    set_unit(2, 32'h0000_0100, 5'd9, 1'b1, 1'b0, 1'b1);
    set_unit(3, 32'h73, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (unit_clear !== 4'b0100 || flush !== 1'b0) begin n_fail++; $display("FAIL redir_grant got %b/%0h want 0100/0", unit_clear, flush); end
    next_cycle();
    unit_valid[2] = 1'b0;
    @(negedge clk);
    ret_model++;
    n_checks++; if (pc_redirect !== 1'b1 || pc_target !== 32'h100) begin n_fail++; $display("FAIL redir_strobe got %0h:%0h want 1:100", pc_redirect, pc_target); end
    n_checks++; if (flush !== 1'b1 || unit_clear !== 4'b1001 || rf_we !== 1'b0) begin n_fail++; $display("FAIL redir_flush got %0h/%b/%0h want 1/1001/0", flush, unit_clear, rf_we); end
    n_checks++; if (retired !== exp_ret()) begin n_fail++; $display("FAIL redir_retired got %0d want %0d", retired, exp_ret()); end
    next_cycle();
    clear_all();
    @(negedge clk);
    n_checks++; if (pc_redirect !== 1'b0 || flush !== 1'b0 || rf_we !== 1'b0 || pc_target !== 32'h100) begin n_fail++; $display("FAIL redir_after got %0h/%0h/%0h/%0h want 0/0/0/100", pc_redirect, flush, rf_we, pc_target); end
  endtask

  task automatic test_trap();
    next_cycle();
    set_unit(3, 32'hbad, 5'd4, 1'b1, 1'b1, 1'b1);
    set_unit(0, 32'h55, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (unit_clear !== 4'b1000) begin n_fail++; $display("FAIL trap_grant got %b want 1000", unit_clear); end
    next_cycle();
    unit_valid[3] = 1'b0;
    @(negedge clk);
    n_checks++; if (trap_valid !== 1'b1 || trap_unit !== 2'd3) begin n_fail++; $display("FAIL trap_raise got %0h:%0h want 1:3", trap_valid, trap_unit); end
    n_checks++; if (pc_redirect !== 1'b0 || rf_we !== 1'b0 || unit_clear !== 4'b0000) begin n_fail++; $display("FAIL trap_quiet got %0h/%0h/%b want 0/0/0000", pc_redirect, rf_we, unit_clear); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (trap_valid !== 1'b1 || unit_clear !== 4'b0000) begin n_fail++; $display("FAIL trap_hold got %0h/%b want 1/0000", trap_valid, unit_clear); end
    next_cycle();
    trap_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (unit_clear !== 4'b0000 || flush !== 1'b0) begin n_fail++; $display("FAIL trap_ack_cycle got %b/%0h want 0000/0", unit_clear, flush); end
    next_cycle();
    trap_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || trap_valid !== 1'b0 || unit_clear !== 4'b0001 || trap_unit !== 2'd3) begin n_fail++; $display("FAIL trap_flush got %0h/%0h/%b/%0h want 1/0/0001/3", flush, trap_valid, unit_clear, trap_unit); end
    next_cycle();
    clear_all();
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || rf_we !== 1'b0 || retired !== exp_ret()) begin n_fail++; $display("FAIL trap_done got %0h/%0h/%0d want 0/0/%0d", flush, rf_we, retired, exp_ret()); end
  endtask

  task automatic test_x0();
    next_cycle();
    set_unit(0, 32'hdead, 5'd0, 1'b1, 1'b0, 1'b0);
    trap_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (unit_clear !== 4'b0001 || flush !== 1'b0) begin n_fail++; $display("FAIL x0_grant got %b/%0h want 0001/0", unit_clear, flush); end
    next_cycle();
    clear_all();
    trap_ack = 1'b0;
    @(negedge clk);
    ret_model++;
    n_checks++; if (rf_we !== 1'b0 || trap_valid !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL x0_nowrite got %0h/%0h/%0h want 0/0/0", rf_we, trap_valid, flush); end
    n_checks++; if (retired !== exp_ret()) begin n_fail++; $display("FAIL x0_retired got %0d want %0d", retired, exp_ret()); end
  endtask

  task automatic test_reset_in_trap();
    next_cycle();
    set_unit(1, 32'h1, 5'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++; if (unit_clear !== 4'b0010) begin n_fail++; $display("FAIL rtrap_grant got %b want 0010", unit_clear); end
    next_cycle();
    unit_valid[1] = 1'b0;
    set_unit(2, 32'h22, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (trap_valid !== 1'b1 || trap_unit !== 2'd1 || unit_clear !== 4'b0000) begin n_fail++; $display("FAIL rtrap_in_trap got %0h/%0h/%b want 1/1/0000", trap_valid, trap_unit, unit_clear); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (trap_valid !== 1'b0 || trap_unit !== 2'd0 || retired !== 64'd0) begin n_fail++; $display("FAIL rtrap_reset_trap got %0h/%0h/%0d want 0/0/0", trap_valid, trap_unit, retired); end
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== '0 || rf_wdata !== '0 || pc_redirect !== 1'b0 || pc_target !== '0) begin n_fail++; $display("FAIL rtrap_reset_regs got %0h/%0h/%0h/%0h/%0h want all 0", rf_we, rf_waddr, rf_wdata, pc_redirect, pc_target); end
    n_checks++; if (flush !== 1'b0 || unit_clear !== 4'b0000) begin n_fail++; $display("FAIL rtrap_reset_comb got %0h/%b want 0/0000", flush, unit_clear); end
    next_cycle();
    rst_n = 1'b1;
    ret_model = 0;
    set_unit(0, 32'h66, 5'd6, 1'b1, 1'b0, 1'b0);
    sb.push_back('{clr: 4'b0001, addr: 5'd6, data: 32'h66});
    @(negedge clk);
    n_checks++; if (unit_clear !== sb[0].clr) begin n_fail++; $display("FAIL rtrap_run_grant got %b want %b", unit_clear, sb[0].clr); end
    next_cycle();
    unit_valid[0] = 1'b0;
    @(negedge clk);
    begin
      exp_t e;
      e = sb.pop_front();
      ret_model++;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== e.addr || rf_wdata !== e.data) begin n_fail++; $display("FAIL rtrap_run_write got %0h:%0h:%0h want 1:%0h:%0h", rf_we, rf_waddr, rf_wdata, e.addr, e.data); end
      n_checks++; if (retired !== exp_ret()) begin n_fail++; $display("FAIL rtrap_retired got %0d want %0d", retired, exp_ret()); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fairness();
    test_redirect();
    test_trap();
    test_x0();
    test_reset_in_trap();
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
